ctrl_fsm_hs: RTL

CTRL_FSM_HS -- requirements
Module: ctrl_fsm_hs

---
 rtl/ctrl_fsm_hs_pkg.sv | 68 ++++++
 rtl/ctrl_fsm_hs_if.sv | 45 ++++
 rtl/ctrl_fsm_hs_alu_dec.sv | 32 +++
 rtl/ctrl_fsm_hs.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ctrl_fsm_hs_pkg.sv
// Shared types and encodings for the multicycle control FSM: states, RV32 opcodes,
// ALU operations and the datapath mux selects.
package ctrl_fsm_hs_pkg;

   typedef enum logic [3:0] {
      ST_FETCH,
      ST_FWAIT,
      ST_DECODE,
      ST_EXEC,
      ST_MADDR,
      ST_MWAIT,
      ST_WBACK,
      ST_BRANCH,
      ST_JUMP,
      ST_TRAP,
      ST_HALT
   } state_t;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLT  = 4'd5;
   localparam logic [3:0] ALU_SLTU = 4'd6;
   localparam logic [3:0] ALU_SLL  = 4'd7;
   localparam logic [3:0] ALU_SRL  = 4'd8;
   localparam logic [3:0] ALU_SRA  = 4'd9;

   // PCS_JALR selects the raw ALU result with bit 0 cleared
   localparam logic [1:0] PCS_ALU    = 2'd0;
   localparam logic [1:0] PCS_ALUOUT = 2'd1;
   localparam logic [1:0] PCS_JALR   = 2'd2;

   localparam logic       ALUA_PC  = 1'b0;
   localparam logic       ALUA_RS1 = 1'b1;
   localparam logic [1:0] ALUB_RS2  = 2'd0;
   localparam logic [1:0] ALUB_IMM  = 2'd1;
   localparam logic [1:0] ALUB_FOUR = 2'd2;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;

   localparam logic [2:0] WB_ALU = 3'd0;
   localparam logic [2:0] WB_MDR = 3'd1;
   localparam logic [2:0] WB_IMM = 3'd2;
   localparam logic [2:0] WB_PC  = 3'd3;

   function automatic logic isWaitState(state_t s);
      return (s == ST_FWAIT) || (s == ST_MWAIT);
   endfunction

endpackage

// File: rtl/ctrl_fsm_hs_if.sv
// Bundle of instruction word, memory handshakes and datapath control lines between
// the control FSM (master) and the datapath/memory side (slave).
interface ctrl_fsm_hs_if #(parameter int CNT_W = 32);
   logic [31:0]      instr;
   logic             imem_ready;
   logic             dmem_ready;
   logic             imem_req;
   logic             dmem_req;
   logic             dmem_we;
   logic [1:0]       mem_size;
   logic             load_unsigned;
   logic             pc_write;
   logic             ir_load;
   logic             ab_load;
   logic             aluout_load;
   logic             mdr_load;
   logic             reg_write;
   logic [1:0]       pc_src;
   logic             alu_a_sel;
   logic [1:0]       alu_b_sel;
   logic [3:0]       alu_op;
   logic [2:0]       imm_sel;
   logic [2:0]       wb_sel;
   logic             branch_en;
   logic [2:0]       branch_cond;
   logic             trap;
   logic             halted;
   logic [CNT_W-1:0] instret;

   modport master (
      input  instr, imem_ready, dmem_ready,
      output imem_req, dmem_req, dmem_we, mem_size, load_unsigned,
             pc_write, ir_load, ab_load, aluout_load, mdr_load, reg_write,
             pc_src, alu_a_sel, alu_b_sel, alu_op, imm_sel, wb_sel,
             branch_en, branch_cond, trap, halted, instret
   );

   modport slave (
      output instr, imem_ready, dmem_ready,
      input  imem_req, dmem_req, dmem_we, mem_size, load_unsigned,
             pc_write, ir_load, ab_load, aluout_load, mdr_load, reg_write,
             pc_src, alu_a_sel, alu_b_sel, alu_op, imm_sel, wb_sel,
             branch_en, branch_cond, trap, halted, instret
   );
endinterface

// File: rtl/ctrl_fsm_hs_alu_dec.sv
// Combinational ALU operation decode from opcode, funct3 and funct7 bit 5.
module ctrl_alu_dec
   import ctrl_fsm_hs_pkg::*;
(
   input  logic [6:0] i_opcode,
   input  logic [2:0] i_funct3,
   input  logic       i_funct7b5,
   output logic [3:0] o_aluOp
);

   logic w_isRegOp;

   assign w_isRegOp = (i_opcode == OPC_OP);

   // Only register-register ops use funct7 to pick SUB; immediates always add
   always_comb begin
      o_aluOp = ALU_ADD;
      if (w_isRegOp || (i_opcode == OPC_OPIMM)) begin
         case (i_funct3)
            3'b000:  o_aluOp = (w_isRegOp && i_funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  o_aluOp = ALU_SLL;
            3'b010:  o_aluOp = ALU_SLT;
            3'b011:  o_aluOp = ALU_SLTU;
            3'b100:  o_aluOp = ALU_XOR;
            3'b101:  o_aluOp = i_funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  o_aluOp = ALU_OR;
            default: o_aluOp = ALU_AND;
         endcase
      end
   end

endmodule

// File: rtl/ctrl_fsm_hs.sv
// Multicycle RV32 control FSM with memory-ready handshakes, wait timeout trap,
// EBREAK halt and a retired-instruction counter.
module ctrl_fsm_hs
   import ctrl_fsm_hs_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 15
)
(
   input  logic            clk,
   input  logic            reset,
   ctrl_fsm_hs_if.master   bus
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   state_t            r_state;
   state_t            w_nextState;
   logic [WAIT_W-1:0] r_waitCnt;
   logic [CNT_W-1:0]  r_instret;
   logic [6:0]        w_opcode;
   logic [2:0]        w_funct3;
   logic [3:0]        w_aluDecOp;
   logic              w_isStore;
   logic              w_timeout;

   assign w_opcode    = bus.instr[6:0];
   assign w_funct3    = bus.instr[14:12];
   assign w_isStore   = (w_opcode == OPC_STORE);
   assign w_timeout   = (r_waitCnt == WAIT_W'(MEM_TIMEOUT - 1));
   assign bus.instret = r_instret;

   ctrl_alu_dec u_aluDec (
      .i_opcode   (w_opcode),
      .i_funct3   (w_funct3),
      .i_funct7b5 (bus.instr[30]),
      .o_aluOp    (w_aluDecOp)
   );

   // Wait counter restarts whenever a wait state is entered or left
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_FETCH;
         r_waitCnt <= '0;
         r_instret <= '0;
      end else begin
         r_state <= w_nextState;
         if (isWaitState(r_state) && (w_nextState == r_state))
            r_waitCnt <= r_waitCnt + 1'b1;
         else
            r_waitCnt <= '0;
         if ((w_nextState == ST_FETCH) && (r_state != ST_FETCH))
            r_instret <= r_instret + 1'b1;
      end
   end

   always_comb begin
      w_nextState       = r_state;
      bus.imem_req      = 1'b0;
      bus.dmem_req      = 1'b0;
      bus.dmem_we       = 1'b0;
      bus.mem_size      = 2'd0;
      bus.load_unsigned = 1'b0;
      bus.pc_write      = 1'b0;
      bus.ir_load       = 1'b0;
      bus.ab_load       = 1'b0;
      bus.aluout_load   = 1'b0;
      bus.mdr_load      = 1'b0;
      bus.reg_write     = 1'b0;
      bus.pc_src        = PCS_ALU;
      bus.alu_a_sel     = ALUA_PC;
      bus.alu_b_sel     = ALUB_RS2;
      bus.alu_op        = ALU_ADD;
      bus.imm_sel       = IMM_I;
      bus.wb_sel        = WB_ALU;
      bus.branch_en     = 1'b0;
      bus.branch_cond   = 3'd0;
      bus.trap          = 1'b0;
      bus.halted        = 1'b0;

      case (r_state)
         // The fetch request stays quiet while reset is held
         ST_FETCH: begin
            bus.imem_req = !reset;
            w_nextState  = ST_FWAIT;
         end
         ST_FWAIT: begin
            bus.imem_req = 1'b1;
            if (bus.imem_ready) begin
               bus.ir_load   = 1'b1;
               bus.pc_write  = 1'b1;
               bus.pc_src    = PCS_ALU;
               bus.alu_a_sel = ALUA_PC;
               bus.alu_b_sel = ALUB_FOUR;
               w_nextState   = ST_DECODE;
            end else if (w_timeout) begin
               w_nextState = ST_TRAP;
            end
         end
         ST_DECODE: begin
            bus.ab_load     = 1'b1;
            bus.aluout_load = 1'b1;
            bus.alu_a_sel   = ALUA_PC;
            bus.alu_b_sel   = ALUB_IMM;
            bus.imm_sel     = (w_opcode == OPC_JAL) ? IMM_J : IMM_B;
            if (bus.instr == INSTR_EBREAK)
               w_nextState = ST_HALT;
            else if (bus.instr == INSTR_NOP)
               w_nextState = ST_FETCH;
            else begin
               case (w_opcode)
                  OPC_OP, OPC_OPIMM, OPC_LUI: w_nextState = ST_EXEC;
                  OPC_LOAD, OPC_STORE:        w_nextState = ST_MADDR;
                  OPC_BRANCH:                 w_nextState = ST_BRANCH;
                  OPC_JAL, OPC_JALR:          w_nextState = ST_JUMP;
                  default:                    w_nextState = ST_TRAP;
               endcase
            end
         end
         ST_EXEC: begin
            bus.reg_write = 1'b1;
            bus.alu_a_sel = ALUA_RS1;
            bus.alu_op    = w_aluDecOp;
            if (w_opcode == OPC_LUI) begin
               bus.wb_sel  = WB_IMM;
               bus.imm_sel = IMM_U;
            end else if (w_opcode == OPC_OPIMM) begin
               bus.wb_sel    = WB_ALU;
               bus.alu_b_sel = ALUB_IMM;
               bus.imm_sel   = IMM_I;
            end else begin
               bus.wb_sel    = WB_ALU;
               bus.alu_b_sel = ALUB_RS2;
            end
            w_nextState = ST_FETCH;
         end
         ST_MADDR: begin
            bus.aluout_load = 1'b1;
            bus.alu_a_sel   = ALUA_RS1;
            bus.alu_b_sel   = ALUB_IMM;
            bus.imm_sel     = w_isStore ? IMM_S : IMM_I;
            w_nextState     = ST_MWAIT;
         end
         ST_MWAIT: begin
            bus.dmem_req      = 1'b1;
            bus.dmem_we       = w_isStore;
            bus.mem_size      = w_funct3[1:0];
            bus.load_unsigned = w_funct3[2];
            if (bus.dmem_ready) begin
               if (w_isStore)
                  w_nextState = ST_FETCH;
               else begin
                  bus.mdr_load = 1'b1;
                  w_nextState  = ST_WBACK;
               end
            end else if (w_timeout) begin
               w_nextState = ST_TRAP;
            end
         end
         ST_WBACK: begin
            bus.reg_write = 1'b1;
            bus.wb_sel    = WB_MDR;
            w_nextState   = ST_FETCH;
         end
         ST_BRANCH: begin
            bus.branch_en   = 1'b1;
            bus.branch_cond = w_funct3;
            bus.pc_src      = PCS_ALUOUT;
            bus.alu_a_sel   = ALUA_RS1;
            bus.alu_b_sel   = ALUB_RS2;
            bus.alu_op      = ALU_SUB;
            w_nextState     = ST_FETCH;
         end
         // PC already holds PC+4, which is the link value written to rd
         ST_JUMP: begin
            bus.reg_write = 1'b1;
            bus.wb_sel    = WB_PC;
            bus.pc_write  = 1'b1;
            if (w_opcode == OPC_JALR) begin
               bus.pc_src    = PCS_JALR;
               bus.alu_a_sel = ALUA_RS1;
               bus.alu_b_sel = ALUB_IMM;
               bus.imm_sel   = IMM_I;
            end else begin
               bus.pc_src = PCS_ALUOUT;
            end
            w_nextState = ST_FETCH;
         end
         ST_TRAP: bus.trap   = 1'b1;
         ST_HALT: bus.halted = 1'b1;
         default: w_nextState = ST_TRAP;
      endcase
   end

endmodule
